// File: rtl/geofence_feeder.sv
// Ping-pong frame buffer feeding the geofence point-in-polygon engine.
// Replays each complete frame one point per cycle and forwards the engine result.
module geofence_feeder #(
    parameter int unsigned NPTS    = 9,
    parameter int unsigned CW      = 10,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_x,
    input  logic [CW-1:0] in_y,
    output logic          fence_rst,
    output logic [CW-1:0] fence_x,
    output logic [CW-1:0] fence_y,
    input  logic          fence_valid,
    input  logic          fence_inside,
    output logic          res_valid,
    output logic          res_inside,
    output logic          err_timeout
);

    localparam int unsigned IW = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NPTS - 1);
    localparam logic [TW-1:0] LastCnt = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StHold, StSend, StWait} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] mem_x [2][NPTS];
    logic [CW-1:0] mem_y [2][NPTS];
    logic [1:0]    full_q, full_d;
    logic          wbank_q, wbank_d;
    logic          rbank_q, rbank_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [IW-1:0] ridx_q, ridx_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          fence_rst_d;
    logic [CW-1:0] fence_x_d, fence_y_d;
    logic          res_valid_d, res_inside_d, err_timeout_d;
    logic          wr_en;

    assign in_ready = !full_q[wbank_q] && !reset;
    assign wr_en    = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        full_d        = full_q;
        wbank_d       = wbank_q;
        rbank_d       = rbank_q;
        widx_d        = widx_q;
        ridx_d        = ridx_q;
        cnt_d         = cnt_q;
        fence_rst_d   = fence_rst;
        fence_x_d     = fence_x;
        fence_y_d     = fence_y;
        res_valid_d   = 1'b0;
        res_inside_d  = res_inside;
        err_timeout_d = err_timeout;

        if (wr_en) begin
            if (widx_q == LastIdx) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
                widx_d          = '0;
            end else begin
                widx_d = widx_q + 1'b1;
            end
        end

        // Writes only target a non-full bank and egress only frees a full one,
        // so the set and clear above/below never hit the same bank.
        unique case (state_q)
            StHold: begin
                if (full_q[rbank_q]) begin
                    state_d     = StSend;
                    ridx_d      = '0;
                    fence_rst_d = 1'b0;
                    fence_x_d   = mem_x[rbank_q][0];
                    fence_y_d   = mem_y[rbank_q][0];
                end else begin
                    fence_rst_d = 1'b1;
                end
            end
            StSend: begin
                if (ridx_q == LastIdx) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    ridx_d    = ridx_q + 1'b1;
                    fence_x_d = mem_x[rbank_q][ridx_d];
                    fence_y_d = mem_y[rbank_q][ridx_d];
                end
            end
            StWait: begin
                if (fence_valid) begin
                    // fence_rst stays low through the pulse cycle; HOLD decides next edge.
                    res_valid_d     = 1'b1;
                    res_inside_d    = fence_inside;
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = !rbank_q;
                    state_d         = StHold;
                end else if (cnt_q == LastCnt) begin
                    err_timeout_d   = 1'b1;
                    fence_rst_d     = 1'b1;
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = !rbank_q;
                    state_d         = StHold;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StHold;
            full_q      <= '0;
            wbank_q     <= 1'b0;
            rbank_q     <= 1'b0;
            widx_q      <= '0;
            ridx_q      <= '0;
            cnt_q       <= '0;
            fence_rst   <= 1'b1;
            fence_x     <= '0;
            fence_y     <= '0;
            res_valid   <= 1'b0;
            res_inside  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wbank_q     <= wbank_d;
            rbank_q     <= rbank_d;
            widx_q      <= widx_d;
            ridx_q      <= ridx_d;
            cnt_q       <= cnt_d;
            fence_rst   <= fence_rst_d;
            fence_x     <= fence_x_d;
            fence_y     <= fence_y_d;
            res_valid   <= res_valid_d;
            res_inside  <= res_inside_d;
            err_timeout <= err_timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_x[wbank_q][widx_q] <= in_x;
            mem_y[wbank_q][widx_q] <= in_y;
        end
    end

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder: ingress, frame replay timing, results and timeout.
module tb_geofence_feeder;

    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_x = '0;
    logic [CW-1:0] in_y = '0;
    logic          fence_rst;
    logic [CW-1:0] fence_x, fence_y;
    logic          fence_valid = 1'b0;
    logic          fence_inside = 1'b0;
    logic          res_valid, res_inside, err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int px [9] = '{100, 50, 150, 200, 150, 100, 50, 20, 60};
    int py [9] = '{100, 50, 50, 100, 150, 200, 150, 100, 60};

    geofence_feeder #(.NPTS(9), .CW(CW), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .fence_rst    (fence_rst),
        .fence_x      (fence_x),
        .fence_y      (fence_y),
        .fence_valid  (fence_valid),
        .fence_inside (fence_inside),
        .res_valid    (res_valid),
        .res_inside   (res_inside),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int off);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_x     = CW'(px[i] + off);
            in_y     = CW'(py[i] + off);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (fence_rst !== 1'b1 || fence_x !== 0 || fence_y !== 0) begin
            n_fail++;
            $display("FAIL reset_fence: got rst=%b x=%0d y=%0d want rst=1 x=0 y=0",
                     fence_rst, fence_x, fence_y);
        end
        n_checks++;
        if (res_valid !== 1'b0 || res_inside !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_res: got rv=%b ri=%b err=%b want 0 0 0",
                     res_valid, res_inside, err_timeout);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 0", in_ready);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        end
    endtask

    // Point 0 appears one edge after the bank-full edge, then 9 gapless points.
    task automatic test_single_frame();
        push_frame(0);
        n_checks++;
        if (fence_rst !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sf_hold: got rst=%b rdy=%b want rst=1 rdy=1", fence_rst, in_ready);
        end
        tick();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fence_rst !== 1'b0 || fence_x !== CW'(px[k]) || fence_y !== CW'(py[k])) begin
                n_fail++;
                $display("FAIL sf_point[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                         k, fence_rst, fence_x, fence_y, px[k], py[k]);
            end
            tick();
        end
        n_checks++;
        if (fence_rst !== 1'b0 || fence_x !== 60 || fence_y !== 60) begin
            n_fail++;
            $display("FAIL sf_wait_hold: got rst=%b (%0d,%0d) want rst=0 (60,60)",
                     fence_rst, fence_x, fence_y);
        end
    endtask

    task automatic test_result();
        tick();
        tick();
        tick();
        fence_valid  = 1'b1;
        fence_inside = 1'b1;
        tick();
        fence_valid  = 1'b0;
        fence_inside = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || res_inside !== 1'b1) begin
            n_fail++;
            $display("FAIL res_pulse: got rv=%b ri=%b want 1 1", res_valid, res_inside);
        end
        tick();
        n_checks++;
        if (res_valid !== 1'b0 || fence_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL res_after: got rv=%b rst=%b want rv=0 rst=1", res_valid, fence_rst);
        end
        // Pulse while in HOLD must be ignored.
        fence_valid  = 1'b1;
        fence_inside = 1'b1;
        tick();
        fence_valid  = 1'b0;
        fence_inside = 1'b0;
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL res_ignored: got rv=%b want 0", res_valid);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1;
            in_x     = CW'(px[i % 9] + ((i < 9) ? 0 : 3));
            in_y     = CW'(py[i % 9] + ((i < 9) ? 0 : 3));
            tick();
            if (i >= 9) begin
                n_checks++;
                if (fence_rst !== 1'b0 || fence_x !== CW'(px[i - 9])
                    || fence_y !== CW'(py[i - 9])) begin
                    n_fail++;
                    $display("FAIL b2b_a[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                             i - 9, fence_rst, fence_x, fence_y, px[i - 9], py[i - 9]);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got rdy=%b want 0", in_ready);
        end
        tick();
        fence_valid  = 1'b1;
        fence_inside = 1'b0;
        tick();
        fence_valid  = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || res_inside !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_res_a: got rv=%b ri=%b rdy=%b want 1 0 1",
                     res_valid, res_inside, in_ready);
        end
        tick();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fence_rst !== 1'b0 || fence_x !== CW'(px[k] + 3)
                || fence_y !== CW'(py[k] + 3)) begin
                n_fail++;
                $display("FAIL b2b_b[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                         k, fence_rst, fence_x, fence_y, px[k] + 3, py[k] + 3);
            end
            tick();
        end
        fence_valid  = 1'b1;
        fence_inside = 1'b1;
        tick();
        fence_valid  = 1'b0;
        fence_inside = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || res_inside !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_res_b: got rv=%b ri=%b want 1 1", res_valid, res_inside);
        end
        tick();
        n_checks++;
        if (fence_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_idle: got rst=%b want 1", fence_rst);
        end
    endtask

    task automatic test_gappy_ingress();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_x     = CW'(px[i] + 7);
            in_y     = CW'(py[i] + 7);
            tick();
            in_valid = 1'b0;
            tick();
        end
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fence_rst !== 1'b0 || fence_x !== CW'(px[k] + 7)
                || fence_y !== CW'(py[k] + 7)) begin
                n_fail++;
                $display("FAIL gap_point[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                         k, fence_rst, fence_x, fence_y, px[k] + 7, py[k] + 7);
            end
            tick();
        end
    endtask

    // Continues from the gappy frame's first WAIT cycle (counter at 0).
    task automatic test_timeout();
        logic seen_res;
        seen_res = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            seen_res = seen_res | res_valid;
        end
        n_checks++;
        if (err_timeout !== 1'b0 || fence_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL to_early: got err=%b rst=%b want 0 0", err_timeout, fence_rst);
        end
        tick();
        seen_res = seen_res | res_valid;
        n_checks++;
        if (err_timeout !== 1'b1 || fence_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: got err=%b rst=%b want 1 1", err_timeout, fence_rst);
        end
        n_checks++;
        if (seen_res !== 1'b0) begin
            n_fail++;
            $display("FAIL to_no_res: got rv seen=%b want 0", seen_res);
        end
        push_frame(11);
        tick();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fence_rst !== 1'b0 || fence_x !== CW'(px[k] + 11)
                || fence_y !== CW'(py[k] + 11)) begin
                n_fail++;
                $display("FAIL to_next[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                         k, fence_rst, fence_x, fence_y, px[k] + 11, py[k] + 11);
            end
            tick();
        end
        fence_valid = 1'b1;
        tick();
        fence_valid = 1'b0;
        n_checks++;
        if (res_valid !== 1'b1 || err_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: got rv=%b err=%b want 1 1", res_valid, err_timeout);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        push_frame(13);
        // Keep pushing junk so a partial frame is in the other bank at reset.
        in_valid = 1'b1;
        in_x     = CW'(900);
        in_y     = CW'(901);
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        n_checks++;
        if (fence_x !== CW'(px[4] + 13) || fence_rst !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_point4: got rst=%b x=%0d want rst=0 x=%0d",
                     fence_rst, fence_x, px[4] + 13);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (fence_rst !== 1'b1 || fence_x !== 0 || fence_y !== 0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_reset: got rst=%b x=%0d y=%0d rdy=%b want 1 0 0 0",
                     fence_rst, fence_x, fence_y, in_ready);
        end
        n_checks++;
        if (err_timeout !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rm_err: got err=%b rv=%b want 0 0", err_timeout, res_valid);
        end
        reset = 1'b0;
        push_frame(17);
        tick();
        for (int k = 0; k < 9; k++) begin
            n_checks++;
            if (fence_rst !== 1'b0 || fence_x !== CW'(px[k] + 17)
                || fence_y !== CW'(py[k] + 17)) begin
                n_fail++;
                $display("FAIL rm_fresh[%0d]: got rst=%b (%0d,%0d) want rst=0 (%0d,%0d)",
                         k, fence_rst, fence_x, fence_y, px[k] + 17, py[k] + 17);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_result();
        test_back_to_back();
        test_gappy_ingress();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/geofence_feeder.md
Name: geofence_feeder

Overview:
- Upstream stage of the geofence point-in-polygon engine.
- Accepts a handshaked stream of coordinate points and buffers them in two frame banks (ping-pong). Each frame is NPTS points: the object first, then the fence vertices.
- Replays each complete frame to the engine one point per cycle, with exact cycle alignment. Between frames it holds the engine in reset so the engine never samples garbage.
- Captures the engine's valid/is_inside result pulse and forwards it, and watches for a hung engine with a timeout.

Parameters:
- NPTS, 9, points per frame (object + vertices); the engine's READ phase consumes exactly this many consecutive samples.
- CW, 10, coordinate width in bits.
- TIMEOUT, 64, maximum WAIT cycles allowed before a frame is abandoned.

Ports:
- clk  in  1  clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- in_valid  in  1  upstream point valid.
- in_ready  out  1  feeder can accept a point.
- in_x  in  CW  point X.
- in_y  in  CW  point Y.
- fence_rst  out  1  drives the engine's reset input; 1 holds the engine idle in READ at count 0.
- fence_x  out  CW  point X to the engine.
- fence_y  out  CW  point Y to the engine.
- fence_valid  in  1  engine result valid (single-cycle pulse).
- fence_inside  in  1  engine is_inside, qualified by fence_valid.
- res_valid  out  1  forwarded result pulse.
- res_inside  out  1  forwarded result.
- err_timeout  out  1  sticky hung-engine flag.

Behaviour:
- All outputs are registered. Reset values: fence_rst=1, fence_x=fence_y=0, res_valid=0, res_inside=0, err_timeout=0, in_ready=0 while reset is high. On reset both banks are empty, wbank=rbank=0, widx=0, and the state is HOLD.
- Ingress:
  - in_ready = !full[wbank] && !reset, derived from registers only; no combinational path from in_valid.
  - A transfer occurs when in_valid && in_ready. It writes bank[wbank][widx] and increments widx.
  - The transfer with widx==NPTS-1 sets full[wbank], toggles wbank and clears widx.
- Egress FSM, states HOLD, SEND, WAIT:
  - HOLD: fence_rst=1. If full[rbank] (registered value) is set, the next cycle shows fence_rst=0 with point 0, and the state becomes SEND.
  - SEND: shows point k on the k-th cycle after fence_rst falls, k=0..NPTS-1, back-to-back with no gaps. After point NPTS-1 the state becomes WAIT.
  - WAIT: fence_rst=0; fence_x/fence_y hold the last point. A cycle counter counts up from 0.
- Result handling, on fence_valid=1 in WAIT:
  - Next cycle: res_valid=1 and res_inside=fence_inside, for exactly one cycle.
  - full[rbank] is cleared and rbank toggles.
  - The cycle after the pulse: if the other bank's registered full flag is set, show point 0 with fence_rst=0 (SEND), matching the engine's OUTPUT→READ return. Otherwise fence_rst=1 (HOLD).
- A bank completed on the same edge that a result arrives is not seen until the following edge. The feeder therefore spends one HOLD cycle, then sends.
- fence_valid outside WAIT is ignored; res_valid stays 0.
- Timeout: if the WAIT counter reaches TIMEOUT-1 without fence_valid:
  - next cycle err_timeout=1 (sticky until reset) and fence_rst=1;
  - the frame is discarded (bank freed, rbank toggles) and the state becomes HOLD;
  - no res_valid is produced.
- Latency with continuous in_valid from cycle c0: full is visible after c0+NPTS-1, HOLD detects it at c0+NPTS, and point 0 appears with fence_rst=0 at c0+NPTS+1.
- Ingress and egress on different banks proceed simultaneously. The bank being written is never the bank being sent.
- Reset mid-operation: the next cycle shows all reset values. Partial ingress frames and frames in flight are discarded.

Test Plan:
- Reset, then 9 back-to-back transfers: obj (100,100), vertices (50,50),(150,50),(200,100),(150,150),(100,200),(50,150),(20,100),(60,60) -> fence_rst falls at c0+10; fence_x reads 100,50,150,200,150,100,50,20,60 on consecutive cycles; then WAIT with (60,60) held.
- In WAIT, pulse fence_valid=1 with fence_inside=1 -> res_valid=1 and res_inside=1 next cycle for one cycle; no second frame, so fence_rst=1 on the cycle after the pulse.
- 18 transfers preloading two frames -> in_ready=0 after transfer 18. After frame 1's fence_valid, frame 2's point 0 appears on the cycle after res_valid with fence_rst=0. in_ready returns to 1 one cycle after fence_valid.
- in_valid toggling every other cycle for 9 points -> points stored in order; egress still emits 9 consecutive cycles with no gaps.
- No fence_valid for 64 WAIT cycles -> err_timeout=1 and fence_rst=1 on the next cycle; res_valid stays 0; a later frame sends normally and err_timeout stays 1.
- Assert reset during SEND at point 4 -> next cycle fence_rst=1, fence_x=0, in_ready=0. After release, a fresh 9-point frame is sent from point 0.
